// File: rtl/e203_lsu_arbt_pkg.sv
// Shared types and payload layout for the LSU ICB 2:1 arbiter.
package e203_lsu_arbt_pkg;

  localparam int CMD_PLD_W = 69;
  localparam int RSP_PLD_W = 34;

  // Requester identity carried through the outstanding-command FIFO.
  typedef logic arbt_id_t;

  localparam arbt_id_t ID_I0 = 1'b0;
  localparam arbt_id_t ID_I1 = 1'b1;

  // Command payload {read, addr[31:0], wdata[31:0], wmask[3:0]}.
  localparam int CMD_WMASK_LSB = 0;
  localparam int CMD_WDATA_LSB = 4;
  localparam int CMD_ADDR_LSB  = 36;
  localparam int CMD_READ_BIT  = 68;

  // Response payload {err, excl_ok, rdata[31:0]}.
  localparam int RSP_RDATA_LSB   = 0;
  localparam int RSP_EXCL_OK_BIT = 32;
  localparam int RSP_ERR_BIT     = 33;

  typedef logic [CMD_PLD_W-1:0] cmd_pld_t;
  typedef logic [RSP_PLD_W-1:0] rsp_pld_t;

endpackage

// File: rtl/e203_lsu_arbt_idfifo.sv
// Synchronous FIFO of requester IDs for commands still awaiting a response.
// Pointers are an index plus a wrap bit; full when indices match and wrap bits differ.
module e203_lsu_arbt_idfifo
  import e203_lsu_arbt_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  arbt_id_t push_id,
  input  logic     pop,
  output arbt_id_t head_id,
  output logic     full,
  output logic     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [AW-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(DEPTH - 1);

  arbt_id_t mem [DEPTH];
  idx_t     wr_idx;
  idx_t     rd_idx;
  logic     wr_wrap;
  logic     rd_wrap;
  logic     do_push;
  logic     do_pop;

  assign full    = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);
  assign empty   = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_id = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx  <= '0;
      wr_wrap <= 1'b0;
    end else if (do_push) begin
      if (wr_idx == LAST_IDX) begin
        wr_idx  <= '0;
        wr_wrap <= !wr_wrap;
      end else begin
        wr_idx <= wr_idx + idx_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx  <= '0;
      rd_wrap <= 1'b0;
    end else if (do_pop) begin
      if (rd_idx == LAST_IDX) begin
        rd_idx  <= '0;
        rd_wrap <= !rd_wrap;
      end else begin
        rd_idx <= rd_idx + idx_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ID_I0;
    end else if (do_push) begin
      mem[wr_idx] <= push_id;
    end
  end

endmodule

// File: rtl/e203_lsu_icb_arbt.sv
// 2:1 ICB arbiter: AGU (port 0) and EAI (port 1) share the LSU memory port.
// Define E203_LSU_ARBT_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module e203_lsu_icb_arbt
  import e203_lsu_arbt_pkg::*;
#(
  parameter int OUTS_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i0_cmd_valid,
  output logic                 i0_cmd_ready,
  input  logic [CMD_PLD_W-1:0] i0_cmd_pld,
  output logic                 i0_rsp_valid,
  input  logic                 i0_rsp_ready,
  output logic [RSP_PLD_W-1:0] i0_rsp_pld,
  input  logic                 i1_cmd_valid,
  output logic                 i1_cmd_ready,
  input  logic [CMD_PLD_W-1:0] i1_cmd_pld,
  output logic                 i1_rsp_valid,
  input  logic                 i1_rsp_ready,
  output logic [RSP_PLD_W-1:0] i1_rsp_pld,
  output logic                 o_cmd_valid,
  input  logic                 o_cmd_ready,
  output logic [CMD_PLD_W-1:0] o_cmd_pld,
  input  logic                 o_rsp_valid,
  output logic                 o_rsp_ready,
  input  logic [RSP_PLD_W-1:0] o_rsp_pld
);

  // Handshakes: a transfer occurs on a rising edge where valid and ready are both high;
  // valid never waits on ready, and once raised it holds with a stable payload until then.

  logic     fifo_full;
  logic     fifo_empty;
  arbt_id_t head_id;
  arbt_id_t arb_pick;
  arbt_id_t grant;
  logic     lock_q;
  arbt_id_t lock_id_q;
  logic     granted_valid;
  logic     cmd_hsk;
  logic     rsp_hsk;

`ifdef E203_LSU_ARBT_RR_EN
  arbt_id_t rr_ptr_q;

  always_comb begin
    arb_pick = ID_I0;
    if (i0_cmd_valid && i1_cmd_valid) arb_pick = rr_ptr_q;
    else if (i1_cmd_valid)            arb_pick = ID_I1;
  end

  // After each accepted command the other port gets first claim.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rr_ptr_q <= ID_I0;
    else if (cmd_hsk) rr_ptr_q <= ~grant;
  end
`else
  always_comb begin
    arb_pick = ID_I0;
    if (!i0_cmd_valid && i1_cmd_valid) arb_pick = ID_I1;
  end
`endif

  // A stalled command keeps its grant so the memory side sees a stable payload.
  assign grant         = lock_q ? lock_id_q : arb_pick;
  assign granted_valid = (grant == ID_I1) ? i1_cmd_valid : i0_cmd_valid;

  assign o_cmd_valid  = granted_valid && !fifo_full;
  assign o_cmd_pld    = (grant == ID_I1) ? i1_cmd_pld : i0_cmd_pld;
  assign i0_cmd_ready = (grant == ID_I0) && o_cmd_ready && !fifo_full;
  assign i1_cmd_ready = (grant == ID_I1) && o_cmd_ready && !fifo_full;
  assign cmd_hsk      = o_cmd_valid && o_cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= ID_I0;
    end else if (cmd_hsk) begin
      lock_q <= 1'b0;
    end else if (o_cmd_valid && !o_cmd_ready) begin
      lock_q    <= 1'b1;
      lock_id_q <= grant;
    end
  end

  // Responses return in command order; the FIFO head names the requester.
  assign i0_rsp_valid = o_rsp_valid && !fifo_empty && (head_id == ID_I0);
  assign i1_rsp_valid = o_rsp_valid && !fifo_empty && (head_id == ID_I1);
  assign o_rsp_ready  = !fifo_empty && ((head_id == ID_I1) ? i1_rsp_ready : i0_rsp_ready);
  assign i0_rsp_pld   = o_rsp_pld;
  assign i1_rsp_pld   = o_rsp_pld;
  assign rsp_hsk      = o_rsp_valid && o_rsp_ready;

  e203_lsu_arbt_idfifo #(
    .DEPTH(OUTS_DEPTH)
  ) u_idfifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (cmd_hsk),
    .push_id(grant),
    .pop    (rsp_hsk),
    .head_id(head_id),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_e203_lsu_icb_arbt.sv
// Directed bench for e203_lsu_icb_arbt with scoreboard queues for command and response routing.
module tb_e203_lsu_icb_arbt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i0_cmd_valid, i0_cmd_ready, i0_rsp_valid, i0_rsp_ready;
  logic        i1_cmd_valid, i1_cmd_ready, i1_rsp_valid, i1_rsp_ready;
  logic        o_cmd_valid, o_cmd_ready, o_rsp_valid, o_rsp_ready;
  logic [68:0] i0_cmd_pld, i1_cmd_pld, o_cmd_pld;
  logic [33:0] i0_rsp_pld, i1_rsp_pld, o_rsp_pld;

  int vectors = 0;
  int miscompares = 0;

  logic [68:0] exp_cmd_q[$];
  logic [35:0] exp_rsp_q[$];

  logic [68:0] pld_a, pld_b, pld_a2, pld_a3;

  e203_lsu_icb_arbt #(.OUTS_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i0_cmd_valid(i0_cmd_valid), .i0_cmd_ready(i0_cmd_ready), .i0_cmd_pld(i0_cmd_pld),
    .i0_rsp_valid(i0_rsp_valid), .i0_rsp_ready(i0_rsp_ready), .i0_rsp_pld(i0_rsp_pld),
    .i1_cmd_valid(i1_cmd_valid), .i1_cmd_ready(i1_cmd_ready), .i1_cmd_pld(i1_cmd_pld),
    .i1_rsp_valid(i1_rsp_valid), .i1_rsp_ready(i1_rsp_ready), .i1_rsp_pld(i1_rsp_pld),
    .o_cmd_valid(o_cmd_valid), .o_cmd_ready(o_cmd_ready), .o_cmd_pld(o_cmd_pld),
    .o_rsp_valid(o_rsp_valid), .o_rsp_ready(o_rsp_ready), .o_rsp_pld(o_rsp_pld)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Check helper
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every handshake against the expected queues.
  always @(negedge clk) begin
    if (rst_n && o_cmd_valid && o_cmd_ready) begin
      vectors++;
      if (exp_cmd_q.size() == 0) begin
        miscompares++;
        $display("FAIL cmd_unexpected: got %0h, expected no command", o_cmd_pld);
      end else begin
        logic [68:0] e;
        e = exp_cmd_q.pop_front();
        if (o_cmd_pld !== e) begin
          miscompares++;
          $display("FAIL cmd_pld: got %0h, expected %0h", o_cmd_pld, e);
        end
      end
    end
    if (rst_n && o_rsp_valid && o_rsp_ready) begin
      logic [35:0] act;
      act = {i1_rsp_valid, i0_rsp_valid, (i1_rsp_valid ? i1_rsp_pld : i0_rsp_pld)};
      vectors++;
      if (exp_rsp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_unexpected: got %0h, expected no response", act);
      end else begin
        logic [35:0] e;
        e = exp_rsp_q.pop_front();
        if (act !== e) begin
          miscompares++;
          $display("FAIL rsp_route: got %0h, expected %0h", act, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    i0_cmd_valid = 1'b0; i0_cmd_pld = '0; i0_rsp_ready = 1'b0;
    i1_cmd_valid = 1'b0; i1_cmd_pld = '0; i1_rsp_ready = 1'b0;
    o_cmd_ready  = 1'b0; o_rsp_valid = 1'b0; o_rsp_pld = '0;
  endtask

  task automatic do_reset();
    step();
    set_idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [35:0] rsp_exp(input logic port, input logic [33:0] pld);
    return {port, ~port, pld};
  endfunction

  function automatic logic exp_grant(input int k);
`ifdef E203_LSU_ARBT_RR_EN
    return logic'(k % 2);
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    pld_a  = {1'b1, 32'h8000_0000, 32'h0000_0000, 4'h0};
    pld_b  = {1'b0, 32'h9000_0010, 32'hDEAD_BEEF, 4'hF};
    pld_a2 = {1'b0, 32'h8000_0004, 32'hCAFE_F00D, 4'h3};
    pld_a3 = {1'b1, 32'h8000_0008, 32'h0000_0000, 4'h0};
    set_idle();
    rst_n = 1'b0;
    #2;
    check("reset_o_cmd_valid", o_cmd_valid, 0);
    check("reset_i0_cmd_ready", i0_cmd_ready, 0);
    check("reset_i1_cmd_ready", i1_cmd_ready, 0);
    check("reset_o_rsp_ready", o_rsp_ready, 0);
    check("reset_rsp_valids", {i0_rsp_valid, i1_rsp_valid}, 0);
    step();
    rst_n = 1'b1;

    // 1: single read on port 0 and its response
    step();
    i0_cmd_valid = 1'b1; i0_cmd_pld = pld_a; o_cmd_ready = 1'b1;
    exp_cmd_q.push_back(pld_a);
    #1;
    check("t1_i0_cmd_ready", i0_cmd_ready, 1);
    check("t1_i1_cmd_ready", i1_cmd_ready, 0);
    step();
    set_idle();
    o_rsp_valid = 1'b1; o_rsp_pld = 34'h0_1234_5678; i0_rsp_ready = 1'b1;
    exp_rsp_q.push_back(rsp_exp(1'b0, 34'h0_1234_5678));
    #1;
    check("t1_i0_rsp_valid", i0_rsp_valid, 1);
    check("t1_i1_rsp_valid", i1_rsp_valid, 0);
    check("t1_i0_rsp_pld", i0_rsp_pld, 34'h0_1234_5678);
    step();
    set_idle();

    // 2: both requesting for 4 cycles; responses drain one per cycle
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      set_idle();
      o_rsp_valid = 1'b1; o_rsp_pld = 34'h2_0000_00A0 + 34'(c);
      i0_rsp_ready = 1'b1; i1_rsp_ready = 1'b1;
      if (c <= 4) begin
        logic g;
        g = exp_grant(c - 1);
        i0_cmd_valid = 1'b1; i0_cmd_pld = pld_a;
        i1_cmd_valid = 1'b1; i1_cmd_pld = pld_b;
        o_cmd_ready = 1'b1;
        exp_cmd_q.push_back(g ? pld_b : pld_a);
        exp_rsp_q.push_back(rsp_exp(g, 34'h2_0000_00A0 + 34'(c + 1)));
        #1;
        check("t2_grant_ready", {i1_cmd_ready, i0_cmd_ready}, {g, ~g});
      end
      step();
    end
    set_idle();

    // 3: stalled port-1 command keeps the grant when port 0 arrives
    do_reset();
    i1_cmd_valid = 1'b1; i1_cmd_pld = pld_b;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        i0_cmd_valid = 1'b1; i0_cmd_pld = pld_a;
      end
      #1;
      check("t3_stall_valid", o_cmd_valid, 1);
      check("t3_stall_pld", o_cmd_pld, pld_b);
      check("t3_stall_i0_ready", i0_cmd_ready, 0);
      step();
    end
    o_cmd_ready = 1'b1;
    exp_cmd_q.push_back(pld_b);
    #1;
    check("t3_hsk_ready", {i1_cmd_ready, i0_cmd_ready}, 2'b10);
    step();
    i1_cmd_valid = 1'b0;
    exp_cmd_q.push_back(pld_a);
    #1;
    check("t3_next_i0_ready", i0_cmd_ready, 1);
    step();
    set_idle();

    // 4: FIFO full blocks a third command until a response pops
    do_reset();
    i0_cmd_valid = 1'b1; i0_cmd_pld = pld_a; o_cmd_ready = 1'b1;
    exp_cmd_q.push_back(pld_a);
    #1;
    check("t4_cmd1_ready", i0_cmd_ready, 1);
    step();
    i0_cmd_pld = pld_a2;
    exp_cmd_q.push_back(pld_a2);
    #1;
    check("t4_cmd2_ready", i0_cmd_ready, 1);
    step();
    i0_cmd_pld = pld_a3;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("t4_full_valid", o_cmd_valid, 0);
      check("t4_full_ready", i0_cmd_ready, 0);
      step();
    end
    o_rsp_valid = 1'b1; o_rsp_pld = 34'h1_0000_0042; i0_rsp_ready = 1'b1;
    exp_rsp_q.push_back(rsp_exp(1'b0, 34'h1_0000_0042));
    #1;
    check("t4_pop_cycle_valid", o_cmd_valid, 0);
    check("t4_pop_rsp_ready", o_rsp_ready, 1);
    step();
    o_rsp_valid = 1'b0;
    exp_cmd_q.push_back(pld_a3);
    #1;
    check("t4_after_pop_valid", o_cmd_valid, 1);
    check("t4_after_pop_ready", i0_cmd_ready, 1);
    step();
    set_idle();

    // 5: head-of-line response waits for its own requester
    do_reset();
    i0_cmd_valid = 1'b1; i0_cmd_pld = pld_a; o_cmd_ready = 1'b1;
    exp_cmd_q.push_back(pld_a);
    step();
    i0_cmd_valid = 1'b0;
    i1_cmd_valid = 1'b1; i1_cmd_pld = pld_b;
    exp_cmd_q.push_back(pld_b);
    step();
    set_idle();
    o_rsp_valid = 1'b1; o_rsp_pld = 34'h0_AAAA_0001; i1_rsp_ready = 1'b1;
    #1;
    check("t5_blocked_rsp_ready", o_rsp_ready, 0);
    check("t5_blocked_valids", {i1_rsp_valid, i0_rsp_valid}, 2'b01);
    step();
    i0_rsp_ready = 1'b1;
    exp_rsp_q.push_back(rsp_exp(1'b0, 34'h0_AAAA_0001));
    #1;
    check("t5_rsp1_ready", o_rsp_ready, 1);
    step();
    o_rsp_pld = 34'h3_BBBB_0002;
    exp_rsp_q.push_back(rsp_exp(1'b1, 34'h3_BBBB_0002));
    #1;
    check("t5_rsp2_valids", {i1_rsp_valid, i0_rsp_valid}, 2'b10);
    check("t5_rsp2_pld", i1_rsp_pld, 34'h3_BBBB_0002);
    step();
    set_idle();

    // 6: reset with two commands outstanding
    do_reset();
    i0_cmd_valid = 1'b1; i0_cmd_pld = pld_a; o_cmd_ready = 1'b1;
    exp_cmd_q.push_back(pld_a);
    step();
    i0_cmd_valid = 1'b0;
    i1_cmd_valid = 1'b1; i1_cmd_pld = pld_b;
    exp_cmd_q.push_back(pld_b);
    step();
    set_idle();
    o_rsp_valid = 1'b1; o_rsp_pld = 34'h0_5555_5555;
    i0_rsp_ready = 1'b1; i1_rsp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t6_in_reset_rsp_ready", o_rsp_ready, 0);
    step();
    rst_n = 1'b1;
    #1;
    check("t6_after_reset_rsp_ready", o_rsp_ready, 0);
    check("t6_after_reset_valids", {i1_rsp_valid, i0_rsp_valid}, 0);
    step();
    set_idle();
    step();

    check("end_cmd_queue_empty", exp_cmd_q.size(), 0);
    check("end_rsp_queue_empty", exp_rsp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
